ladder_job_scheduler: RTL

- Sequences one Curve448 Montgomery-ladder job on the error-detecting iterator core.
- Buffers a 448-bit operand from the host as 8×56-bit words, then resets, loads and runs the iterator.
- Captures the 8-word result and retries the job when the iterator flags a fault or times out.
- Sits between the host bus and the iterator; the iterator is never driven directly by the host.

---
 rtl/ladder_job_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ladder_job_scheduler.sv
// Ladder job scheduler: buffers a 448-bit operand from the host and runs one
// Montgomery-ladder job on the iterator, retrying on fault or timeout.
module ladder_job_scheduler #(
  parameter int WORD_W     = 56,
  parameter int N_WORDS    = 8,
  parameter int BIT_NUMBER = 448,
  parameter int MAX_RETRY  = 2,
  parameter int TIMEOUT    = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              job_fail,
  output logic              busy,
  output logic              it_reset,
  output logic              it_enable,
  output logic [WORD_W-1:0] it_bus_input,
  output logic [8:0]        it_bit_number,
  input  logic [WORD_W-1:0] it_bus_output,
  input  logic              it_done,
  input  logic              it_error
);

  localparam int WC_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int AC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] LAST_WORD    = WC_W'(N_WORDS - 1);
  localparam logic [AC_W-1:0] RETRY_LIM    = AC_W'(MAX_RETRY);
  localparam logic [TC_W-1:0] TIMEOUT_LAST = TC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_FEED, S_WAIT, S_CAPTURE, S_CHECK, S_DRAIN
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wcnt;
  logic [AC_W-1:0]   r_attempts;
  logic [TC_W-1:0]   r_tcnt;
  logic              r_err_seen;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_job_fail;
  logic              r_busy;
  logic              r_it_reset;
  logic              r_it_enable;
  logic [WORD_W-1:0] r_out_data;
  logic [WORD_W-1:0] r_it_bus_input;
  logic [WORD_W-1:0] r_inbuf  [N_WORDS];
  logic [WORD_W-1:0] r_outbuf [N_WORDS];

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last_word;
  logic [WC_W-1:0]   w_wcnt_next;

  assign w_in_fire   = in_valid && r_in_ready && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_out_fire  = r_out_valid && out_ready && (r_state == S_DRAIN);
  assign w_last_word = (r_wcnt == LAST_WORD);
  assign w_wcnt_next = r_wcnt + 1'b1;

  // Data buffers carry no reset: a mid-job reset leaves them stale but unused.
  // The result buffer is zeroed at job start so a job that never captures drains zeros.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_inbuf[r_wcnt] <= in_data;
    end
    if ((r_state == S_LOAD) && w_in_fire && w_last_word) begin
      for (int i = 0; i < N_WORDS; i++) begin
        r_outbuf[i] <= '0;
      end
    end else if (r_state == S_CAPTURE) begin
      r_outbuf[r_wcnt] <= it_bus_output;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wcnt         <= '0;
      r_attempts     <= '0;
      r_tcnt         <= '0;
      r_err_seen     <= 1'b0;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_data     <= '0;
      r_job_fail     <= 1'b0;
      r_busy         <= 1'b0;
      r_it_reset     <= 1'b1;
      r_it_enable    <= 1'b0;
      r_it_bus_input <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_it_reset <= 1'b1;
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_wcnt  <= w_wcnt_next;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_in_fire) begin
            if (w_last_word) begin
              r_wcnt     <= '0;
              r_in_ready <= 1'b0;
              r_attempts <= '0;
              r_job_fail <= 1'b0;
              r_state    <= S_KICK;
            end else begin
              r_wcnt <= w_wcnt_next;
            end
          end
        end
        S_KICK: begin
          r_err_seen     <= 1'b0;
          r_it_reset     <= 1'b0;
          r_it_enable    <= 1'b1;
          r_it_bus_input <= r_inbuf[0];
          r_wcnt         <= '0;
          r_state        <= S_FEED;
        end
        S_FEED: begin
          // A completion before the operand is fully fed means the iterator is misbehaving.
          if (it_error || it_done) begin
            r_err_seen <= 1'b1;
          end
          if (w_last_word) begin
            r_wcnt         <= '0;
            r_tcnt         <= '0;
            r_it_bus_input <= '0;
            r_state        <= S_WAIT;
          end else begin
            r_wcnt         <= w_wcnt_next;
            r_it_bus_input <= r_inbuf[w_wcnt_next];
          end
        end
        S_WAIT: begin
          if (it_error) begin
            r_err_seen <= 1'b1;
          end
          if (it_done) begin
            r_state <= S_CAPTURE;
          end else if (r_tcnt == TIMEOUT_LAST) begin
            r_err_seen  <= 1'b1;
            r_it_enable <= 1'b0;
            r_state     <= S_CHECK;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (it_error) begin
            r_err_seen <= 1'b1;
          end
          if (w_last_word) begin
            r_wcnt      <= '0;
            r_it_enable <= 1'b0;
            r_state     <= S_CHECK;
          end else begin
            r_wcnt <= w_wcnt_next;
          end
        end
        S_CHECK: begin
          if (r_err_seen && (r_attempts < RETRY_LIM)) begin
            r_attempts <= r_attempts + 1'b1;
            r_it_reset <= 1'b1;
            r_state    <= S_KICK;
          end else begin
            if (r_err_seen) begin
              r_job_fail <= 1'b1;
            end
            r_wcnt      <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= r_outbuf[0];
            r_out_last  <= (LAST_WORD == '0);
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            if (w_last_word) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= '0;
              r_job_fail  <= 1'b0;
              r_busy      <= 1'b0;
              r_it_reset  <= 1'b1;
              r_in_ready  <= 1'b1;
              r_wcnt      <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_wcnt     <= w_wcnt_next;
              r_out_data <= r_outbuf[w_wcnt_next];
              r_out_last <= (w_wcnt_next == LAST_WORD);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_last      = r_out_last;
  assign job_fail      = r_job_fail;
  assign busy          = r_busy;
  assign it_reset      = r_it_reset;
  assign it_enable     = r_it_enable;
  assign it_bus_input  = r_it_bus_input;
  assign it_bit_number = 9'(BIT_NUMBER);

endmodule
